// File: rtl/text_vram_pkg.sv
// Shared constants and types for the text VRAM arbiter.
// Screen geometry: 80x30 characters packed four ASCII codes per 32-bit word.
package text_vram_pkg;

  localparam int unsigned COLS           = 80;
  localparam int unsigned ROWS           = 30;
  localparam int unsigned CHARS_PER_WORD = 4;
  localparam int unsigned VRAM_DEPTH     = (COLS * ROWS) / CHARS_PER_WORD;
  localparam logic [31:0] CLEAR_WORD     = 32'h2020_2020;

  // Host transfer sequencer states
  typedef enum logic [1:0] {
    H_IDLE = 2'd0,
    H_RD   = 2'd1,
    H_DONE = 2'd2
  } host_state_e;

endpackage

// File: rtl/text_vram_arbiter_if.sv
// Avalon-MM host port of the text VRAM arbiter.
//   master : host side (drives read/write/address/byteenable/writedata)
//   slave  : arbiter side (drives readdata/waitrequest)
interface text_vram_arbiter_if #(
  parameter int unsigned ADDR_W = 10
);

  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [3:0]        byteenable;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              waitrequest;

  modport master (
    output read, write, address, byteenable, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  read, write, address, byteenable, writedata,
    output readdata, waitrequest
  );

endinterface

// File: rtl/text_vram_clear.sv
// Clear-engine sequencer: walks word addresses 0..DEPTH-1 while busy,
// advancing only on cycles where the arbiter grants it the VRAM port.
// A start seen while the host is mid-transfer is remembered and launched
// once the host returns to idle; a start while busy is dropped.
//   clk, rst_n : clock, async active-low reset
//   start      : clear request pulse
//   host_idle  : host sequencer is in H_IDLE
//   grant      : VRAM port granted to the clear engine this cycle
//   req        : clear engine wants the VRAM port
//   addr       : word address to write
//   busy       : clear in progress
module text_vram_clear
  import text_vram_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = VRAM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              host_idle,
  input  logic              grant,
  output logic              req,
  output logic [ADDR_W-1:0] addr,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic              busy_q;
  logic              pend_q;
  logic [ADDR_W-1:0] cnt_q;

  // Busy/pending/counter sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      pend_q <= 1'b0;
      cnt_q  <= '0;
    end else if (busy_q) begin
      if (grant) begin
        if (cnt_q == LAST_ADDR) begin
          busy_q <= 1'b0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end else if ((start || pend_q) && host_idle) begin
      busy_q <= 1'b1;
      pend_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start) begin
      pend_q <= 1'b1;
    end
  end

  assign req  = busy_q;
  assign addr = cnt_q;
  assign busy = busy_q;

endmodule

// File: rtl/text_vram_arbiter.sv
// Single-port text VRAM arbiter. One VRAM access per cycle with priority
// display > clear engine > host. The display path has a fixed 2-cycle read
// latency; the host is stalled through avl.waitrequest.
// Optional clear engine is built only when TEXT_VRAM_CLEAR_EN is defined;
// otherwise clear_start is ignored and clear_busy is tied low.
// Ports:
//   Clk, Reset           : clock, async active-low reset
//   disp_req/addr        : draw-pipeline read request (never stalled)
//   disp_valid/rdata     : draw-pipeline read return, 2 cycles after request
//   avl                  : Avalon-MM host slave port (interface)
//   clear_start/busy     : clear engine control/status
//   ram_addr/we/be/wdata : VRAM macro command (combinational, same cycle)
//   ram_rdata            : VRAM read data, 1-cycle synchronous latency
module text_vram_arbiter
  import text_vram_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DEPTH      = VRAM_DEPTH,
  parameter logic [31:0] CLEAR_FILL = CLEAR_WORD
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                disp_req,
  input  logic [ADDR_W-1:0]   disp_addr,
  output logic                disp_valid,
  output logic [31:0]         disp_rdata,
  text_vram_arbiter_if.slave  avl,
  input  logic                clear_start,
  output logic                clear_busy,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_we,
  output logic [3:0]          ram_be,
  output logic [31:0]         ram_wdata,
  input  logic [31:0]         ram_rdata
);

  // DEPTH must be below 2**ADDR_W for the range compare to be meaningful
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  host_state_e       state, state_next;
  logic [ADDR_W-1:0] last_addr;
  logic              host_issue;
  logic              host_rd;
  logic              rd_oor;
  logic              disp_p1_valid;
  logic              disp_p1_oor;
  logic              clear_req;
  logic              clear_grant;
  logic [ADDR_W-1:0] clear_addr;

  // A simultaneous read+write is treated as a read
  assign host_rd = avl.read;

`ifdef TEXT_VRAM_CLEAR_EN
  text_vram_clear #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clear (
    .clk       (Clk),
    .rst_n     (Reset),
    .start     (clear_start),
    .host_idle (state == H_IDLE),
    .grant     (clear_grant),
    .req       (clear_req),
    .addr      (clear_addr),
    .busy      (clear_busy)
  );
`else
  logic unused_clear;
  assign clear_req    = 1'b0;
  assign clear_addr   = '0;
  assign clear_busy   = 1'b0;
  assign unused_clear = ^{clear_start, clear_grant};
`endif

  // Host FSM state register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= H_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Port arbitration, VRAM command and host next-state
  always_comb begin
    state_next  = state;
    ram_addr    = last_addr;
    ram_we      = 1'b0;
    ram_be      = 4'h0;
    ram_wdata   = 32'h0;
    host_issue  = 1'b0;
    clear_grant = 1'b0;

    if (disp_req) begin
      ram_addr = disp_addr;
    end else if (clear_req) begin
      clear_grant = 1'b1;
      ram_addr    = clear_addr;
      ram_we      = 1'b1;
      ram_be      = 4'hF;
      ram_wdata   = CLEAR_FILL;
    end else if ((state == H_IDLE) && (avl.read || avl.write)) begin
      host_issue = 1'b1;
      ram_addr   = avl.address;
      if (!host_rd) begin
        // Out-of-range writes complete on the bus but never touch the RAM
        ram_we    = (avl.address < DEPTH_A);
        ram_be    = avl.byteenable;
        ram_wdata = avl.writedata;
      end
    end

    case (state)
      H_IDLE:  if (host_issue) state_next = host_rd ? H_RD : H_DONE;
      H_RD:    state_next = H_DONE;
      H_DONE:  state_next = H_IDLE;
      default: state_next = H_IDLE;
    endcase
  end

  assign avl.waitrequest = (avl.read || avl.write) && (state != H_DONE);

  // Address hold register and host read capture
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      last_addr    <= '0;
      rd_oor       <= 1'b0;
      avl.readdata <= 32'h0;
    end else begin
      last_addr <= ram_addr;
      if (host_issue) begin
        rd_oor <= (avl.address >= DEPTH_A);
      end
      if (state == H_RD) begin
        avl.readdata <= rd_oor ? 32'h0 : ram_rdata;
      end
    end
  end

  // Two-stage display return pipe: RAM latency stage then output register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      disp_p1_valid <= 1'b0;
      disp_p1_oor   <= 1'b0;
      disp_valid    <= 1'b0;
      disp_rdata    <= 32'h0;
    end else begin
      disp_p1_valid <= disp_req;
      disp_p1_oor   <= (disp_addr >= DEPTH_A);
      disp_valid    <= disp_p1_valid;
      if (disp_p1_valid) begin
        disp_rdata <= disp_p1_oor ? 32'h0 : ram_rdata;
      end
    end
  end

endmodule
